// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helpers for the multiplexed 7-segment display.
// Segment codes are active low: bit 7 is the decimal point and bits 6:0 are g..a.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK  = 8'hFF;
  localparam seg_t SEG_DASH   = 8'hBF;
  localparam int   SEG_DP_BIT = 7;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
    seg_t code;
    case (nibble)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // One spare nibble is kept only when the binary range can exceed the digits shown;
  // that nibble is what raises overflow.
  function automatic int bcd_nibbles(input int num_digits, input int bin_w);
    longint p10;
    longint p2;
    p10 = 1;
    p2  = 1;
    for (int i = 0; i < num_digits; i++) p10 = p10 * 10;
    for (int i = 0; i < bin_w; i++) p2 = p2 * 2;
    return (p2 > p10) ? num_digits + 1 : num_digits;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Load handshake between the value producer and the display converter.
// A transfer happens on a rising clk edge where load && ready; load while ready=0 is
// dropped (not queued), and value need only be stable on the transfer edge.
interface seg7_scan_display_if #(
  parameter int BIN_W = 14
) ();

  logic [BIN_W-1:0] value;
  logic             load;
  logic             ready;

  modport master (output value, output load, input ready);
  modport slave  (input value, input load, output ready);

endinterface

// File: rtl/seg7_bin2bcd.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// Result and overflow are valid during the single-cycle done pulse.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BIN_W-1:0]        value,
  input  logic                    load,
  output logic                    ready,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    ovf,
  output conv_state_e             state
);

  localparam int NB = bcd_nibbles(NUM_DIGITS, BIN_W);
  localparam int CW = $clog2(BIN_W + 1);

  conv_state_e      state_q;
  conv_state_e      state_d;
  logic [BIN_W-1:0] bin_q;
  logic [NB*4-1:0]  bcd_q;
  logic [NB*4-1:0]  bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             spill_q;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        ready = 1'b1;
        if (load) state_d = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        if (cnt_q == CW'(BIN_W - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: begin
        done    = 1'b1;
        state_d = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // A bit shifted out of the top nibble means the value exceeded the register;
  // keep it sticky so such values still report overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      spill_q <= 1'b0;
    end else if (state_q == CONV_IDLE && load) begin
      bin_q   <= value;
      bcd_q   <= '0;
      cnt_q   <= '0;
      spill_q <= 1'b0;
    end else if (state_q == CONV_SHIFT) begin
      bcd_q   <= {bcd_adj[NB*4-2:0], bin_q[BIN_W-1]};
      spill_q <= spill_q | bcd_adj[NB*4-1];
      bin_q   <= bin_q << 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign bcd = bcd_q[NUM_DIGITS*4-1:0];

  always_comb begin
    ovf = spill_q;
    for (int i = NUM_DIGITS; i < NB; i++) begin
      ovf = ovf | (bcd_q[i*4 +: 4] != 4'd0);
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed NUM_DIGITS common-anode 7-segment driver: converts a loaded binary value
// to BCD, then scans the digits with leading-zero blanking, decimal points and overflow dashes.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_display_if.slave    bus,
  input  logic                  en,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output seg_t                  seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow,
  output conv_state_e           conv_state
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    conv_done;
  logic [NUM_DIGITS*4-1:0] conv_bcd;
  logic                    conv_ovf;
  logic [NUM_DIGITS*4-1:0] disp_bcd;
  logic                    disp_ovf;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    hi_zero;
  seg_t                    code;
  seg_t                    seg_d;
  logic [NUM_DIGITS-1:0]   an_d;

  seg7_bin2bcd #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .value (bus.value),
    .load  (bus.load),
    .ready (bus.ready),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf),
    .state (conv_state)
  );

  // Digits and overflow are committed together so the scan never sees a half result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      disp_ovf <= conv_ovf;
    end
  end

  assign overflow = disp_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // hi_zero: the current digit and every digit above it are zero.
  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    hi_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_nib = disp_bcd[i*4 +: 4];
        cur_dp  = dp_mask[i];
      end
      if (i >= int'(idx) && disp_bcd[i*4 +: 4] != 4'd0) hi_zero = 1'b0;
    end
  end

  always_comb begin
    code = SEG_BLANK;
    if (disp_ovf)                                   code = SEG_DASH;
    else if (blank_lz && idx != '0 && hi_zero)      code = SEG_BLANK;
    else                                            code = bcd_to_seg(cur_nib);
    if (cur_dp) code[SEG_DP_BIT] = 1'b0;
    seg_d = en ? code : SEG_BLANK;
    an_d  = en ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with NUM_DIGITS=4, BIN_W=14, SCAN_DIV=4.
// Expected {an,seg} per digit come from an arithmetic decimal model, queued then compared.
module tb_seg7_scan_display;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          blank_lz;
  logic [ND-1:0] dp_mask;
  seg_t          seg;
  logic [ND-1:0] an;
  logic          overflow;
  conv_state_e   conv_state;

  seg7_scan_display_if #(.BIN_W(BW)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW),
    .SCAN_DIV   (SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .en         (en),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .an         (an),
    .overflow   (overflow),
    .conv_state (conv_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          model_val;
  logic [11:0] exp_q[$];

  function automatic seg_t dig_code(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic seg_t exp_seg(input int d, input int val, input bit blz, input bit dp);
    seg_t s;
    int   p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (val >= 10000)              s = 8'hBF;
    else if (blz && d > 0 && val < p) s = 8'hFF;
    else                           s = dig_code((val / p) % 10);
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

  // driver tasks
  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic align_digit0(input string name);
    logic [ND-1:0] prev;
    int            k;
    prev = an;
    k    = 0;
    @(negedge clk);
    while (!(prev != 4'hE && an == 4'hE) && k < 100) begin
      prev = an;
      k++;
      @(negedge clk);
    end
    if (k >= 100) begin
      n_err++;
      $display("FAIL %s align: an=%h never switched to E", name, an);
    end
  endtask

  task automatic do_load(input int v, output int low_cnt);
    int k;
    k = 0;
    while (!bus.ready && k < 100) begin k++; @(negedge clk); end
    bus.value = BW'(v);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    low_cnt = 0;
    while (!bus.ready && low_cnt < 60) begin low_cnt++; @(negedge clk); end
    model_val = v;
  endtask

  // scoreboard: queue one full frame, then compare as the scan produces it
  task automatic check_frame(input string name);
    logic [11:0]   e;
    logic [ND-1:0] one;
    one = 4'b0001;
    for (int d = 0; d < ND; d++)
      exp_q.push_back({~(one << d), exp_seg(d, model_val, blank_lz, dp_mask[d])});
    align_digit0(name);
    for (int d = 0; d < ND; d++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({an, seg} !== e) begin
        n_err++;
        $display("FAIL %s digit%0d: an/seg=%h/%h expected %h/%h", name, d, an, seg, e[11:8], e[7:0]);
      end
      cycles(SD - 1);
      n_cmp++;
      if (an !== e[11:8]) begin
        n_err++;
        $display("FAIL %s dwell%0d: an=%h expected %h", name, d, an, e[11:8]);
      end
      cycles(1);
    end
  endtask

  task automatic check_ready_low(input string name, input int got);
    n_cmp++;
    if (got !== BW + 1) begin
      n_err++;
      $display("FAIL %s ready_low: %0d cycles expected %0d", name, got, BW + 1);
    end
  endtask

  task automatic check_ovf(input string name, input logic e);
    n_cmp++;
    if (overflow !== e) begin
      n_err++;
      $display("FAIL %s overflow: %b expected %b", name, overflow, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; blank_lz = 1'b1; dp_mask = '0;
    bus.value = '0; bus.load = 1'b0; model_val = 0;
    cycles(3);
    n_cmp++;
    if ({seg, an, bus.ready, overflow} !== {8'hFF, 4'hF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset: seg=%h an=%h ready=%b ovf=%b expected FF F 1 0", seg, an, bus.ready, overflow);
    end
    rst_n = 1'b1;
    check_frame("reset_lz");
    blank_lz = 1'b0;
    check_frame("reset_nolz");
    blank_lz = 1'b1;
  endtask

  task automatic test_load_basic();
    int lc;
    do_load(1234, lc);
    check_ready_low("load1234", lc);
    check_ovf("load1234", 1'b0);
    check_frame("load1234");
  endtask

  task automatic test_overflow();
    int lc;
    do_load(10000, lc);
    check_ovf("ovf10000", 1'b1);
    check_frame("ovf10000");
    do_load(9999, lc);
    check_ovf("max9999", 1'b0);
    check_frame("max9999");
    do_load(16383, lc);
    check_ovf("ovf16383", 1'b1);
    do_load(7, lc);
    check_ovf("load7", 1'b0);
    check_frame("load7");
  endtask

  task automatic test_dp();
    int lc;
    dp_mask = 4'b0010;
    do_load(5, lc);
    check_frame("dp5");
    dp_mask = 4'b1001;
    do_load($urandom_range(100, 999), lc);
    check_frame("dp_rand");
    dp_mask = '0;
  endtask

  task automatic test_back_to_back();
    int lc;
    int k;
    k = 0;
    while (!bus.ready && k < 100) begin k++; @(negedge clk); end
    bus.value = BW'(42); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    lc = 0;
    for (int c = 0; c < 60 && !bus.ready; c++) begin
      lc++;
      bus.load = (lc == 3);
      if (lc == 3) bus.value = BW'(99);
      @(negedge clk);
    end
    bus.load = 1'b0;
    model_val = 42;
    check_ready_low("b2b", lc);
    cycles(BW + 4);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b queued: ready=%b expected 1 (second load must not run)", bus.ready);
    end
    check_frame("b2b42");
  endtask

  task automatic test_enable();
    logic [ND-1:0] one;
    one = 4'b0001;
    align_digit0("en_align");
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({seg, an} !== {8'hFF, 4'hF}) begin
      n_err++;
      $display("FAIL en_off: seg=%h an=%h expected FF F", seg, an);
    end
    cycles(8);
    n_cmp++;
    if ({seg, an} !== {8'hFF, 4'hF}) begin
      n_err++;
      $display("FAIL en_off_hold: seg=%h an=%h expected FF F", seg, an);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({an, seg} !== {~(one << 2), exp_seg(2, model_val, blank_lz, 1'b0)}) begin
      n_err++;
      $display("FAIL en_resume: an/seg=%h/%h expected %h/%h", an, seg, ~(one << 2),
               exp_seg(2, model_val, blank_lz, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (!bus.ready && k < 100) begin k++; @(negedge clk); end
    bus.value = BW'(1234); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    cycles(5);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg, an, bus.ready, overflow} !== {8'hFF, 4'hF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid: seg=%h an=%h ready=%b ovf=%b expected FF F 1 0", seg, an, bus.ready, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    cycles(BW + 4);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready: ready=%b expected 1", bus.ready);
    end
    check_frame("rst_mid_zero");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load_basic();
    test_overflow();
    test_dp();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
